// File: rtl/nco_mixer_dump_pkg.sv
// -----------------------------------------------------------------------------
// nco_mixer_dump_pkg
// Shared definitions for the quadrature mixer / integrate-and-dump stage that
// sits right after the carrier NCO in the DSSS demodulator.
//   - sample, NCO and output word widths, product width derivation
//   - branch kind (in-phase / quadrature) used to select product negation
//   - per-accept window operation shared by the top and both branches
//   - saturate(): clamps a wide signed value into the signed output word
// No ports (package).
// -----------------------------------------------------------------------------
package nco_mixer_dump_pkg;

  localparam int DIN_W        = 8;
  localparam int NCO_W        = 10;
  localparam int PW           = DIN_W + NCO_W;
  localparam int OUT_W        = 16;
  localparam int DUMP_LEN_DEF = 8;
  localparam int SHIFT_DEF    = 4;

  // Width of the generic value handed to saturate(); comfortably wider than
  // any accumulator this block can be built with.
  localparam int SAT_W        = 64;

  typedef enum logic {
    BR_IN_PHASE,
    BR_QUADRATURE
  } branch_e;

  // What the accumulators do with the product arriving from stage 1.
  typedef enum logic [1:0] {
    WIN_IDLE,
    WIN_RESTART,
    WIN_DUMP,
    WIN_ACCUM
  } win_op_e;

  typedef struct packed {
    logic signed [OUT_W-1:0] value;
    logic                    clamped;
  } sat_t;

  // Clamp a signed value into [-(2^(OUT_W-1)), 2^(OUT_W-1)-1] and report
  // whether clamping was needed.
  function automatic sat_t saturate(input logic signed [SAT_W-1:0] x);
    sat_t                    res;
    logic signed [SAT_W-1:0] maxV;
    logic signed [SAT_W-1:0] minV;
    maxV = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    minV = ~maxV;
    if (x > maxV) begin
      res.value   = maxV[OUT_W-1:0];
      res.clamped = 1'b1;
    end else if (x < minV) begin
      res.value   = minV[OUT_W-1:0];
      res.clamped = 1'b1;
    end else begin
      res.value   = x[OUT_W-1:0];
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/nco_mixer_dump_if.sv
// -----------------------------------------------------------------------------
// nco_mixer_dump_if
// Bundles the sample/NCO input stream and the decimated I/Q result stream of
// the mixer-dump stage.
//   din        signed IF sample
//   din_valid  din qualifier
//   nco_valid  NCO output qualifier
//   fsin_i     signed NCO sine
//   fcos_i     signed NCO cosine
//   sync_i     start a new dump window with this accepted sample
//   i_out      signed in-phase dump result (held between dumps)
//   q_out      signed quadrature dump result (held between dumps)
//   dout_valid one-cycle strobe marking a fresh i_out/q_out
//   ovf        saturation occurred on this dump
// master: the upstream source / consumer side.  slave: the mixer-dump block.
// -----------------------------------------------------------------------------
interface nco_mixer_dump_if;
  import nco_mixer_dump_pkg::*;

  logic signed [DIN_W-1:0] din;
  logic                    din_valid;
  logic                    nco_valid;
  logic signed [NCO_W-1:0] fsin_i;
  logic signed [NCO_W-1:0] fcos_i;
  logic                    sync_i;
  logic signed [OUT_W-1:0] i_out;
  logic signed [OUT_W-1:0] q_out;
  logic                    dout_valid;
  logic                    ovf;

  modport master (
    output din, din_valid, nco_valid, fsin_i, fcos_i, sync_i,
    input  i_out, q_out, dout_valid, ovf
  );

  modport slave (
    input  din, din_valid, nco_valid, fsin_i, fcos_i, sync_i,
    output i_out, q_out, dout_valid, ovf
  );

endinterface

// File: rtl/nco_mixer_dump_branch.sv
// -----------------------------------------------------------------------------
// nco_mixer_dump_branch
// One arm (I or Q) of the quadrature mixer: registered sample x NCO product,
// integrate-and-dump accumulator, and the shift/saturate of the dump result.
// The quadrature arm negates its product so that Q = -din*sin.
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   accept_i  sample and NCO word are both valid this cycle
//   din_i     signed IF sample
//   coef_i    signed NCO word (cos for I, sin for Q)
//   winOp_i   accumulator operation for the product currently in stage 1
//   dout_o    registered, saturated dump result (holds between dumps)
//   clamp_o   the dump result being formed this cycle needs clamping
// -----------------------------------------------------------------------------
module nco_mixer_dump_branch
  import nco_mixer_dump_pkg::*;
#(
  parameter branch_e KIND     = BR_IN_PHASE,
  parameter int      DUMP_LEN = DUMP_LEN_DEF,
  parameter int      SHIFT    = SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    accept_i,
  input  logic signed [DIN_W-1:0] din_i,
  input  logic signed [NCO_W-1:0] coef_i,
  input  win_op_e                 winOp_i,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    clamp_o
);

  // Accumulator grows by log2 of the window length so a full window of
  // worst-case products can never wrap.
  localparam int AW = PW + $clog2(DUMP_LEN);

  logic signed [PW-1:0]    prod_q;
  logic signed [PW-1:0]    prod_d;
  logic signed [AW-1:0]    acc_q;
  logic signed [AW-1:0]    acc_d;
  logic signed [AW-1:0]    winSum;
  logic signed [AW-1:0]    winShift;
  logic signed [OUT_W-1:0] dout_q;
  logic signed [OUT_W-1:0] dout_d;
  sat_t                    sat;

  // Stage 1: product is only captured on accepted samples; a gap leaves the
  // previous product in place, and it is ignored downstream because the
  // matching pipe valid is low.  The product always fits in PW bits, and so
  // does its negation (the most negative product is never reached).
  always_comb begin
    prod_d = prod_q;
    if (accept_i) begin
      if (KIND == BR_QUADRATURE) begin
        prod_d = -(PW'(din_i) * PW'(coef_i));
      end else begin
        prod_d = PW'(din_i) * PW'(coef_i);
      end
    end
  end

  // Dump value includes the product that closes the window; the arithmetic
  // shift truncates toward minus infinity before clamping to the output word.
  always_comb begin
    winSum   = acc_q + AW'(prod_q);
    winShift = winSum >>> SHIFT;
    sat      = saturate(SAT_W'(winShift));
    clamp_o  = sat.clamped;
  end

  // Stage 2: a restart seeds the window with the new product (any partial
  // window is discarded), a dump empties the accumulator, otherwise integrate.
  // The output word only changes on a dump so consumers can sample it late.
  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    case (winOp_i)
      WIN_RESTART: acc_d = AW'(prod_q);
      WIN_DUMP: begin
        acc_d  = '0;
        dout_d = sat.value;
      end
      WIN_ACCUM:   acc_d = winSum;
      default:     acc_d = acc_q;
    endcase
  end

  // State registers; reset clears the pipeline product, the window and the
  // held output.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/nco_mixer_dump.sv
// -----------------------------------------------------------------------------
// nco_mixer_dump
// Quadrature down-converter stage downstream of the carrier NCO.  Mixes the
// real IF sample stream with NCO cos/sin, integrates DUMP_LEN accepted samples
// per chip-aligned window and emits scaled, saturated I/Q words.
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   mix   slave side of nco_mixer_dump_if (sample/NCO in, I/Q dump out)
// Timing: the last accepted sample of a window at cycle t produces
// dout_valid at cycle t+2.
// -----------------------------------------------------------------------------
module nco_mixer_dump
  import nco_mixer_dump_pkg::*;
#(
  parameter int DUMP_LEN = DUMP_LEN_DEF,
  parameter int SHIFT    = SHIFT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  nco_mixer_dump_if.slave mix
);

  localparam int             CW   = $clog2(DUMP_LEN);
  localparam logic [CW-1:0]  LAST = CW'(DUMP_LEN - 1);

  logic                    accept;
  logic                    v1_q;
  logic                    v1_d;
  logic                    s1_q;
  logic                    s1_d;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_d;
  logic                    doutValid_q;
  logic                    doutValid_d;
  logic                    ovf_q;
  logic                    ovf_d;
  win_op_e                 winOp;
  logic                    clampI;
  logic                    clampQ;
  logic signed [OUT_W-1:0] iOut;
  logic signed [OUT_W-1:0] qOut;

  assign accept = mix.din_valid & mix.nco_valid;

  // Stage-1 qualifiers travel alongside the registered products; sync only
  // counts when its sample is actually accepted.
  always_comb begin
    v1_d = accept;
    s1_d = mix.sync_i & accept;
  end

  // Decide what the window does with the product now in stage 1.  Sync wins
  // over a pending dump, so a sync on the last sample suppresses that dump.
  always_comb begin
    winOp = WIN_IDLE;
    cnt_d = cnt_q;
    if (v1_q) begin
      if (s1_q) begin
        winOp = WIN_RESTART;
        cnt_d = CW'(1);
      end else if (cnt_q == LAST) begin
        winOp = WIN_DUMP;
        cnt_d = '0;
      end else begin
        winOp = WIN_ACCUM;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // The strobe and overflow flag are registered together with the dump words
  // so all four outputs change on the same edge; ovf drops with the strobe.
  always_comb begin
    doutValid_d = (winOp == WIN_DUMP);
    ovf_d       = (winOp == WIN_DUMP) & (clampI | clampQ);
  end

  // Shared control registers; reset flushes the pipe and restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      cnt_q       <= '0;
      doutValid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      s1_q        <= s1_d;
      cnt_q       <= cnt_d;
      doutValid_q <= doutValid_d;
      ovf_q       <= ovf_d;
    end
  end

  nco_mixer_dump_branch #(
    .KIND     (BR_IN_PHASE),
    .DUMP_LEN (DUMP_LEN),
    .SHIFT    (SHIFT)
  ) uBranchI (
    .clk      (clk),
    .rst      (rst),
    .accept_i (accept),
    .din_i    (mix.din),
    .coef_i   (mix.fcos_i),
    .winOp_i  (winOp),
    .dout_o   (iOut),
    .clamp_o  (clampI)
  );

  nco_mixer_dump_branch #(
    .KIND     (BR_QUADRATURE),
    .DUMP_LEN (DUMP_LEN),
    .SHIFT    (SHIFT)
  ) uBranchQ (
    .clk      (clk),
    .rst      (rst),
    .accept_i (accept),
    .din_i    (mix.din),
    .coef_i   (mix.fsin_i),
    .winOp_i  (winOp),
    .dout_o   (qOut),
    .clamp_o  (clampQ)
  );

  assign mix.i_out      = iOut;
  assign mix.q_out      = qOut;
  assign mix.dout_valid = doutValid_q;
  assign mix.ovf        = ovf_q;

endmodule
